// File: rtl/mitchell_pkg.sv
// Shared Mitchell-log helpers and default widths.
// Used by the Mitchell divider and multiplier.
package mitchell_pkg;

  localparam int WA_DEF = 17;
  localparam int WB_DEF = 9;

  function automatic int clog(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index of the most significant set bit; 0 when x is zero.
  function automatic int lod_pos(input logic [31:0] x);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (x[i]) p = i;
    return p;
  endfunction

  typedef struct packed {
    logic [clog(WA_DEF)-1:0] k;
    logic [WA_DEF-2:0]       frac;
  } log_t;

endpackage

// File: rtl/mitchell_lod.sv
// Leading-one detect plus mantissa normalise:
// |x| -> characteristic k, FRAC-bit fraction, zero flag.
module mitchell_lod
  import mitchell_pkg::*;
#(
  parameter int W    = WA_DEF,
  parameter int FRAC = WA_DEF - 1,
  parameter int KW   = clog(W)
) (
  input  logic [W-1:0]    i_mag,
  output logic [KW-1:0]   o_k,
  output logic [FRAC-1:0] o_frac,
  output logic            o_zero
);

  logic [KW-1:0]   w_k;
  logic [FRAC-1:0] w_rem;

  // Bit k itself never survives: it is either masked or lies above FRAC.
  always_comb begin
    w_k   = KW'(lod_pos(32'(i_mag)));
    w_rem = FRAC'(i_mag);
    w_rem = w_rem & ~(FRAC'(1) << w_k);
    w_rem = w_rem << (FRAC - int'(w_k));
  end

  assign o_k    = w_k;
  assign o_frac = w_rem;
  assign o_zero = ~|i_mag;

endmodule

// File: rtl/mitchell_div_pipe.sv
// Approximate signed divider, q ~= a/b via Mitchell logs.
// Three compute stages plus output register, one shared enable.
module mitchell_div_pipe
  import mitchell_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] q,
  output logic          div_zero,
  output logic          ovf
);

  localparam int FRAC = WA - 1;
  localparam int KA   = clog(WA);
  localparam int KB   = clog(WB);
  localparam int EW   = KA + 2;

  localparam logic [WA-1:0] QMAX = {1'b0, {(WA-1){1'b1}}};
  localparam logic [WA-1:0] QMIN = {1'b1, {(WA-1){1'b0}}};

  typedef struct packed {
    logic            v;
    logic            sign;
    logic            za;
    logic            zb;
    logic [KA-1:0]   ka;
    logic [KB-1:0]   kb;
    logic [FRAC-1:0] fa;
    logic [FRAC-1:0] fb;
  } s1_t;

  typedef struct packed {
    logic          v;
    logic          sign;
    logic          za;
    logic          zb;
    logic [EW-1:0] e;
    logic [FRAC:0] m;
  } s2_t;

  typedef struct packed {
    logic          v;
    logic          sign;
    logic          za;
    logic          zb;
    logic [WA-1:0] qmag;
  } s3_t;

  logic            w_stall;
  logic [WA-1:0]   w_abs_a;
  logic [WB-1:0]   w_abs_b;
  logic [KA-1:0]   w_ka;
  logic [KB-1:0]   w_kb;
  logic [FRAC-1:0] w_fa;
  logic [FRAC-1:0] w_fb;
  logic            w_za;
  logic            w_zb;
  s1_t             w_s1;
  s2_t             w_s2;
  s3_t             w_s3;
  logic [WA-1:0]   w_q;
  logic            w_dz;
  logic            w_ovf;

  s1_t             r_s1;
  s2_t             r_s2;
  s3_t             r_s3;
  logic            r_out_valid;
  logic [WA-1:0]   r_q;
  logic            r_dz;
  logic            r_ovf;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // |-2^(WA-1)| wraps to 2^(WA-1), which is correct as unsigned.
  assign w_abs_a = a[WA-1] ? -a : a;
  assign w_abs_b = b[WB-1] ? -b : b;

  mitchell_lod #(
    .W    (WA),
    .FRAC (FRAC),
    .KW   (KA)
  ) u_lod_a (
    .i_mag  (w_abs_a),
    .o_k    (w_ka),
    .o_frac (w_fa),
    .o_zero (w_za)
  );

  mitchell_lod #(
    .W    (WB),
    .FRAC (FRAC),
    .KW   (KB)
  ) u_lod_b (
    .i_mag  (w_abs_b),
    .o_k    (w_kb),
    .o_frac (w_fb),
    .o_zero (w_zb)
  );

  always_comb begin
    w_s1      = '0;
    w_s1.v    = in_valid;
    w_s1.sign = a[WA-1] ^ b[WB-1];
    w_s1.za   = w_za;
    w_s1.zb   = w_zb;
    w_s1.ka   = w_ka;
    w_s1.kb   = w_kb;
    w_s1.fa   = w_fa;
    w_s1.fb   = w_fb;
  end

  // Modular fa-fb under a leading 1 yields 2+fa-fb when fa<fb.
  always_comb begin
    w_s2      = '0;
    w_s2.v    = r_s1.v;
    w_s2.sign = r_s1.sign;
    w_s2.za   = r_s1.za;
    w_s2.zb   = r_s1.zb;
    w_s2.m    = {1'b1, r_s1.fa - r_s1.fb};
    w_s2.e    = EW'(r_s1.ka) - EW'(r_s1.kb)
              - EW'(r_s1.fa < r_s1.fb);
  end

  always_comb begin
    w_s3      = '0;
    w_s3.v    = r_s2.v;
    w_s3.sign = r_s2.sign;
    w_s3.za   = r_s2.za;
    w_s3.zb   = r_s2.zb;
    if (!r_s2.e[EW-1])
      w_s3.qmag = r_s2.m >> (FRAC - int'(r_s2.e));
  end

  // qmag top bit only for |a|=2^(WA-1), |b|=1.
  always_comb begin
    w_q   = '0;
    w_dz  = 1'b0;
    w_ovf = 1'b0;
    if (r_s3.v) begin
      if (r_s3.zb) begin
        w_dz = 1'b1;
      end else if (!r_s3.za) begin
        if (r_s3.qmag[WA-1]) begin
          w_q   = r_s3.sign ? QMIN : QMAX;
          w_ovf = ~r_s3.sign;
        end else begin
          w_q = r_s3.sign ? -r_s3.qmag : r_s3.qmag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (!w_stall) begin
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_s3        <= w_s3;
      r_out_valid <= r_s3.v;
      r_q         <= w_q;
      r_dz        <= w_dz;
      r_ovf       <= w_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign div_zero  = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mitchell_div_pipe.sv
// Scoreboard bench for mitchell_div_pipe.
// Reference is a real-valued Mitchell model.
module tb_mitchell_div_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] a;
  logic [8:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] q;
  logic        div_zero;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [16:0] q;
    logic        dz;
    logic        ov;
    int          ia;
    int          ib;
  } exp_t;

  exp_t        sb[$];
  exp_t        src_e[$];
  logic [16:0] src_a[$];
  logic [8:0]  src_b[$];

  mitchell_div_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [16:0] av, input logic [8:0] bv);
    exp_t r;
    int   ia, ib, xa, xb, ka, kb, qm;
    real  fa, fb, qr;
    bit   neg;
    ia = int'($signed(av));
    ib = int'($signed(bv));
    r.ia = ia; r.ib = ib;
    r.q = '0; r.dz = 1'b0; r.ov = 1'b0;
    if (ib == 0) begin
      r.dz = 1'b1;
      return r;
    end
    if (ia == 0) return r;
    xa = (ia < 0) ? -ia : ia;
    xb = (ib < 0) ? -ib : ib;
    ka = 0;
    while ((1 << (ka + 1)) <= xa) ka++;
    kb = 0;
    while ((1 << (kb + 1)) <= xb) kb++;
    fa = real'(xa) / real'(1 << ka) - 1.0;
    fb = real'(xb) / real'(1 << kb) - 1.0;
    if (fa >= fb) qr = (1.0 + fa - fb) * (2.0 ** (ka - kb));
    else          qr = (2.0 + fa - fb) * (2.0 ** (ka - kb - 1));
    qm  = $rtoi(qr);
    neg = (ia < 0) != (ib < 0);
    if (qm > 65535) begin
      if (neg) r.q = 17'h10000;
      else begin
        r.q  = 17'h0FFFF;
        r.ov = 1'b1;
      end
    end else begin
      r.q = neg ? 17'(-qm) : 17'(qm);
    end
    return r;
  endfunction

  function automatic exp_t cexp(input int ia, input int ib, input int qv,
                                input bit dz, input bit ov);
    exp_t r;
    r.ia = ia; r.ib = ib; r.q = 17'(qv); r.dz = dz; r.ov = ov;
    return r;
  endfunction

  task automatic drive_stream(input int mode, input bit bound);
    bit          pstall = 1'b0;
    logic [16:0] pq = '0;
    logic        pdz = 1'b0;
    logic        pov = 1'b0;
    exp_t        e;
    int          cyc = 0;
    real         tr, qs, err, lim;
    while ((src_a.size() > 0 || sb.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      if (src_a.size() > 0) begin
        in_valid = 1'b1;
        a = src_a[0];
        b = src_b[0];
      end else begin
        in_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready,
                 !(out_valid && !out_ready));
      end
      if (pstall) begin
        checks++;
        if (out_valid !== 1'b1 || q !== pq || div_zero !== pdz || ovf !== pov) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b q=%h dz=%b ov=%b want v=1 q=%h dz=%b ov=%b",
                   cyc, out_valid, q, div_zero, ovf, pq, pdz, pov);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out cyc=%0d got q=%h want no output", cyc, q);
        end else begin
          e = sb.pop_front();
          if (q !== e.q || div_zero !== e.dz || ovf !== e.ov) begin
            errors++;
            $display("FAIL result a=%0d b=%0d got q=%0d dz=%b ov=%b want q=%0d dz=%b ov=%b",
                     e.ia, e.ib, $signed(q), div_zero, ovf, $signed(e.q), e.dz, e.ov);
          end
          if (bound && !e.dz && e.ia != 0) begin
            checks++;
            tr  = real'(e.ia) / real'(e.ib);
            qs  = real'($signed(q));
            err = (qs > tr) ? qs - tr : tr - qs;
            lim = 0.13 * ((tr < 0.0) ? -tr : tr) + 1.0;
            if (err > lim) begin
              errors++;
              $display("FAIL mitchell_bound a=%0d b=%0d got q=%0d want within %f of %f",
                       e.ia, e.ib, $signed(q), lim, tr);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(src_e.pop_front());
        void'(src_a.pop_front());
        void'(src_b.pop_front());
      end
      pstall = out_valid && !out_ready;
      pq  = q;
      pdz = div_zero;
      pov = ovf;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (src_a.size() != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout got pending=%0d outstanding=%0d want 0 0",
               src_a.size(), sb.size());
    end
    src_a.delete(); src_b.delete(); src_e.delete(); sb.delete();
  endtask

  task automatic add_op(input int ia, input int ib, input exp_t e);
    src_a.push_back(17'(ia));
    src_b.push_back(9'(ib));
    src_e.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++;
    if (q !== 17'd0) begin errors++; $display("FAIL rst_q got=%h want=0", q); end
    checks++;
    if (div_zero !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rst_flags got dz=%b ov=%b want 0 0", div_zero, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = 17'd15; b = 9'd5; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL latency got=%0d want=3", n); end
    checks++;
    if (q !== 17'd3 || div_zero !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL lat_result got q=%0d dz=%b ov=%b want q=3 dz=0 ov=0",
                         $signed(q), div_zero, ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_vectors();
    add_op(15, 5, cexp(15, 5, 3, 0, 0));
    add_op(100, 7, cexp(100, 7, 14, 0, 0));
    add_op(-80, 4, cexp(-80, 4, -20, 0, 0));
    add_op(3, 9, cexp(3, 9, 0, 0, 0));
    add_op(0, 18, cexp(0, 18, 0, 0, 0));
    add_op(123, 0, cexp(123, 0, 0, 1, 0));
    add_op(0, 0, cexp(0, 0, 0, 1, 0));
    add_op(-65536, -1, cexp(-65536, -1, 65535, 0, 1));
    add_op(-65536, 1, cexp(-65536, 1, -65536, 0, 0));
    add_op(-3, 9, cexp(-3, 9, 0, 0, 0));
    add_op(65535, -256, cexp(65535, -256, -255, 0, 0));
    drive_stream(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ta[8] = '{15, 100, -80, 20, -1000, 32767, 7, -65536};
    int tb[8] = '{5, 7, 4, 4, 3, -128, 7, 255};
    for (int i = 0; i < 8; i++)
      add_op(ta[i], tb[i], model(17'(ta[i]), 9'(tb[i])));
    drive_stream(1, 1'b1);
  endtask

  task automatic test_reset_flush();
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = 17'd40; b = 9'd2; out_ready = 1'b1;
    @(negedge clk);
    a = 17'd50; b = 9'd5;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || q !== 17'd0) begin
      errors++; $display("FAIL flush_out got v=%b q=%h want v=0 q=0", out_valid, q);
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL flush_ghost got=%0d want=0 outputs", n); end
    in_valid = 1'b1; a = 17'd20; b = 9'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (n != 3 || q !== 17'd5) begin
      errors++; $display("FAIL flush_next got lat=%0d q=%0d want lat=3 q=5", n, $signed(q));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [16:0] ra;
    logic [8:0]  rb;
    for (int i = 0; i < 300; i++) begin
      ra = 17'($urandom);
      rb = 9'($urandom);
      if (i % 23 == 0) rb = '0;
      if (i % 31 == 0) ra = 17'h10000;
      if (i % 37 == 0) ra = '0;
      add_op(int'($signed(ra)), int'($signed(rb)), model(ra, rb));
    end
    drive_stream(2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
